// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

   typedef enum logic [2:0] {
      HDR,
      DATA,
      CHK,
      RUN,
      ERROR
   } boot_state_e;

   localparam int         BYTES_PER_WORD = 4;
   localparam int         HDR_BYTES_DEF  = 2;
   localparam logic [7:0] CHK_INIT       = 8'h00;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Little-endian byte-to-word shift-in; word_valid/word are presented in the
// same cycle the final byte of a word is offered, for the caller to register.
module word_assembler
   import imem_boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  idx_q;
   logic [23:0] sh_q;

   // First byte drifts down to bits [7:0] as later bytes enter at the top.
   assign word_valid = byte_valid && (idx_q == 2'(BYTES_PER_WORD - 1));
   assign word       = {byte_in, sh_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= 2'd0;
         sh_q  <= 24'd0;
      end else if (clr) begin
         idx_q <= 2'd0;
         sh_q  <= 24'd0;
      end else if (byte_valid) begin
         idx_q <= idx_q + 2'd1;
         sh_q  <= {byte_in, sh_q[23:8]};
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: header word count, payload words into imem, then core release.
// Optional trailing XOR checksum byte when IMEM_BOOT_CHECKSUM_EN is defined.
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int i_addr_bits = 6,
   parameter int HDR_BYTES   = HDR_BYTES_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_byte,
   output logic                   rx_ready,
   output logic                   imem_we,
   output logic [i_addr_bits-1:0] imem_addr,
   output logic [31:0]            imem_wdata,
   output logic                   core_rst_n,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int NW  = 8 * HDR_BYTES;
   localparam int HCW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
   localparam int WCW = i_addr_bits + 1;
   localparam longint unsigned MAX_WORDS = 64'(1) << i_addr_bits;

`ifdef IMEM_BOOT_CHECKSUM_EN
   localparam boot_state_e POST_LOAD = CHK;
`else
   localparam boot_state_e POST_LOAD = RUN;
`endif

   boot_state_e    state_q, state_nx;
   logic [NW-1:0]  n_q, n_nx;
   logic [HCW-1:0] hdr_cnt;
   logic [WCW-1:0] w_q;
   logic           acc, restart, last_hdr, load_nx;
   logic           word_valid;
   logic [31:0]    word;

   assign acc      = rx_valid && rx_ready;
   assign restart  = start && (state_q == RUN || state_q == ERROR);
   assign last_hdr = (hdr_cnt == HCW'(HDR_BYTES - 1));
   assign load_nx  = (state_nx == HDR) || (state_nx == DATA) || (state_nx == CHK);

`ifdef IMEM_BOOT_CHECKSUM_EN
   logic [7:0] chk_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         chk_q <= CHK_INIT;
      else if (restart)
         chk_q <= CHK_INIT;
      else if (acc && state_q == DATA)
         chk_q <= chk_q ^ rx_byte;
   end
`endif

   word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clr        (restart),
      .byte_valid (acc && state_q == DATA),
      .byte_in    (rx_byte),
      .word_valid (word_valid),
      .word       (word)
   );

   always_comb begin
      state_nx = state_q;
      n_nx     = n_q;
      for (int i = 0; i < HDR_BYTES; i++)
         if (hdr_cnt == HCW'(i)) n_nx[8*i +: 8] = rx_byte;
      case (state_q)
         HDR: begin
            if (acc && last_hdr) begin
               if (n_nx == '0)
                  state_nx = POST_LOAD;
               else if (64'(n_nx) > MAX_WORDS)
                  state_nx = ERROR;
               else
                  state_nx = DATA;
            end
         end
         DATA: begin
            if (word_valid && (64'(w_q) + 64'd1 == 64'(n_q)))
               state_nx = POST_LOAD;
         end
`ifdef IMEM_BOOT_CHECKSUM_EN
         CHK: begin
            if (acc)
               state_nx = (rx_byte == chk_q) ? RUN : ERROR;
         end
`endif
         RUN, ERROR: begin
            if (start)
               state_nx = HDR;
         end
         default: state_nx = HDR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= HDR;
         rx_ready   <= 1'b1;
         busy       <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         core_rst_n <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         n_q        <= '0;
         hdr_cnt    <= '0;
         w_q        <= '0;
      end else begin
         state_q  <= state_nx;
         rx_ready <= load_nx;
         busy     <= load_nx;
         done     <= (state_nx == RUN);
         err      <= (state_nx == ERROR);
         // Release only once RUN is already held, so the final write lands first.
         core_rst_n <= (state_q == RUN) && (state_nx == RUN);
         imem_we    <= word_valid;
         if (word_valid) begin
            imem_wdata <= word;
            imem_addr  <= w_q[i_addr_bits-1:0];
            w_q        <= w_q + WCW'(1);
         end
         if (acc && state_q == HDR) begin
            n_q     <= n_nx;
            hdr_cnt <= last_hdr ? '0 : hdr_cnt + HCW'(1);
         end
         if (restart) begin
            n_q     <= '0;
            hdr_cnt <= '0;
            w_q     <= '0;
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: images are generated at random, the
// expected writes are queued from the byte image and popped on every imem_we.
module tb_imem_boot_loader;

   localparam int AW    = 6;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst, start, rx_valid;
   logic [7:0]    rx_byte;
   logic          rx_ready, imem_we, core_rst_n, busy, done, err;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] pay[$];
   int         vectors     = 0;
   int         miscompares = 0;

   imem_boot_loader #(.i_addr_bits(AW), .HDR_BYTES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst_n (core_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0d data %h, expected no write", imem_addr, imem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", 32'(imem_addr), 32'(e.addr));
            check("write_data", imem_wdata, e.data);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog");
   end

   // gap: 0 back-to-back, 1 random idle cycles, 2 idle before every byte
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      if (gap == 2 || (gap == 1 && $urandom_range(0, 2) == 0)) begin
         rx_valid = 1'b0;
         @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_byte  = b;
      while (rx_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t == 20) begin
         vectors++;
         miscompares++;
         $display("FAIL rx_ready_timeout: got rx_ready=%b, expected 1", rx_ready);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic gen_payload(input int n);
      pay.delete();
      for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
   endtask

   task automatic pulse_start();
      rx_valid = 1'b1;
      rx_byte  = 8'hA5;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_err", 32'(err), 32'd0);
      check("start_done", 32'(done), 32'd0);
      check("start_core_rst_n", 32'(core_rst_n), 32'd0);
      check("start_rx_ready", 32'(rx_ready), 32'd1);
   endtask

   // Expected outcome straight from the image: N words at addresses 0..N-1,
   // oversize header -> ERROR with no writes, bad checksum -> ERROR after writes.
   task automatic send_image(input int n, input int gap, input bit bad_chk);
      bit         hdr_err = (n > DEPTH);
      bit         err_exp = hdr_err || bad_chk;
      logic [7:0] x       = 8'h00;
      if (!hdr_err)
         for (int i = 0; i < n; i++)
            exp_q.push_back(wr_t'{addr: AW'(i),
                                  data: {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]}});
      for (int i = 0; i < 2; i++) send_byte(8'(n >> (8 * i)), gap);
      if (!hdr_err) begin
         for (int i = 0; i < 4 * n; i++) begin
            send_byte(pay[i], gap);
            x ^= pay[i];
         end
`ifdef IMEM_BOOT_CHECKSUM_EN
         send_byte(bad_chk ? (x ^ 8'h01) : x, gap);
`endif
      end
      check("end_done", 32'(done), 32'(!err_exp));
      check("end_err", 32'(err), 32'(err_exp));
      check("end_busy", 32'(busy), 32'd0);
      check("end_rx_ready", 32'(rx_ready), 32'd0);
      check("entry_core_rst_n", 32'(core_rst_n), 32'd0);
      @(negedge clk);
      check("release_core_rst_n", 32'(core_rst_n), 32'(!err_exp));
      #1;
      check("writes_pending", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic probe_idle(input bit exp_done);
      rx_valid = 1'b1;
      rx_byte  = 8'($urandom);
      repeat (3) begin
         @(negedge clk);
         check("idle_rx_ready", 32'(rx_ready), 32'd0);
         check("idle_done", 32'(done), 32'(exp_done));
      end
      rx_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_rx_ready", 32'(rx_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
      check("rst_imem_we", 32'(imem_we), 32'd0);
      check("rst_imem_addr", 32'(imem_addr), 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Two known instructions, back-to-back bytes
      pay = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      send_image(2, 0, 1'b0);
      probe_idle(1'b1);

      // Empty image
      pulse_start();
      gen_payload(0);
      send_image(0, 0, 1'b0);

      // One word too many for the memory
      pulse_start();
      send_image(DEPTH + 1, 0, 1'b0);
      probe_idle(1'b0);

      // Single word with valid toggling every cycle
      pulse_start();
      gen_payload(1);
      send_image(1, 2, 1'b0);

`ifdef IMEM_BOOT_CHECKSUM_EN
      pulse_start();
      pay = {8'h13, 8'h00, 8'h00, 8'h00};
      send_image(1, 0, 1'b0);
      pulse_start();
      send_image(1, 0, 1'b1);
      pulse_start();
      gen_payload(2);
      send_image(2, 1, 1'b0);
`endif

      // Reset after six payload bytes, then a full reload
      pulse_start();
      gen_payload(3);
      exp_q.push_back(wr_t'{addr: AW'(0), data: {pay[3], pay[2], pay[1], pay[0]}});
      send_byte(8'd3, 0);
      send_byte(8'd0, 0);
      for (int i = 0; i < 6; i++) send_byte(pay[i], 0);
      rst = 1'b1;
      #1;
      check("midrst_core_rst_n", 32'(core_rst_n), 32'd0);
      check("midrst_busy", 32'(busy), 32'd1);
      check("midrst_rx_ready", 32'(rx_ready), 32'd1);
      check("midrst_imem_we", 32'(imem_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_writes", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      send_image(3, 0, 1'b0);

      // Full memory, then random sizes and random gaps
      pulse_start();
      gen_payload(DEPTH);
      send_image(DEPTH, 1, 1'b0);
      repeat (5) begin
         int n;
         n = $urandom_range(1, DEPTH);
         pulse_start();
         gen_payload(n);
         send_image(n, $urandom_range(0, 2), 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
